// File: rtl/reg_native_arb_pkg.sv
// Shared types and constants for the native register interface arbiter.
package reg_native_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StGap
  } arb_state_e;

  localparam logic [31:0] TimeoutRdataDefault = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting slot at or after the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned NReq = 4,
  parameter int unsigned IdxW = $clog2(NReq)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NReq-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            vld_o
);

  always_comb begin
    logic [IdxW-1:0] slot;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    slot  = '0;
    for (int unsigned off = 0; off < NReq; off++) begin
      slot = IdxW'((32'(ptr_i) + off) % NReq);
      if (!vld_o && req_i[slot]) begin
        vld_o       = 1'b1;
        gnt_o[slot] = 1'b1;
        idx_o       = slot;
      end
    end
  end

endmodule

// File: rtl/reg_native_if_arbiter.sv
// Round-robin arbiter sharing one native register interface among N_REQ requesters,
// with a watchdog that error-acks transactions the downstream never answers.
module reg_native_if_arbiter
  import reg_native_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned BUS_ADDR_WIDTH = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = TimeoutRdataDefault
) (
  input  logic                              native_clk,
  input  logic                              native_rst_n,
  input  logic                              soft_rst,
  input  logic [N_REQ-1:0]                  up_req_vld,
  input  logic [N_REQ*BUS_ADDR_WIDTH-1:0]   up_addr,
  input  logic [N_REQ-1:0]                  up_wr_en,
  input  logic [N_REQ-1:0]                  up_rd_en,
  input  logic [N_REQ*BUS_DATA_WIDTH-1:0]   up_wr_data,
  output logic [N_REQ-1:0]                  up_ack_vld,
  output logic [BUS_DATA_WIDTH-1:0]         up_rd_data,
  output logic                              up_err,
  output logic                              dn_req_vld,
  output logic [BUS_ADDR_WIDTH-1:0]         dn_addr,
  output logic                              dn_wr_en,
  output logic                              dn_rd_en,
  output logic [BUS_DATA_WIDTH-1:0]         dn_wr_data,
  input  logic                              dn_ack_vld,
  input  logic [BUS_DATA_WIDTH-1:0]         dn_rd_data,
  output logic [$clog2(N_REQ)-1:0]          grant_id
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BUS_DATA_WIDTH-1:0] TimeoutRdataExt = BUS_DATA_WIDTH'(TIMEOUT_RDATA);

  arb_state_e state_q, state_d;

  logic [IdxW-1:0]           ptr_q, ptr_d;
  logic [IdxW-1:0]           grant_q, grant_d;
  logic [WdW-1:0]            wd_q, wd_d;
  logic [N_REQ-1:0]          up_ack_vld_q, up_ack_vld_d;
  logic [BUS_DATA_WIDTH-1:0] up_rd_data_q, up_rd_data_d;
  logic                      up_err_q, up_err_d;
  logic                      dn_req_vld_q, dn_req_vld_d;
  logic [BUS_ADDR_WIDTH-1:0] dn_addr_q, dn_addr_d;
  logic                      dn_wr_en_q, dn_wr_en_d;
  logic                      dn_rd_en_q, dn_rd_en_d;
  logic [BUS_DATA_WIDTH-1:0] dn_wr_data_q, dn_wr_data_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]  arb_idx;
  logic             arb_vld;
  logic             wd_expire;

  rr_arbiter #(
    .NReq (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i (up_req_vld),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // wd_q counts completed BUSY cycles; expiry is the TIMEOUT_CYCLES-th BUSY cycle.
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge native_clk or negedge native_rst_n) begin
    if (!native_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (arb_vld) state_d = StBusy;
      StBusy:  if (dn_ack_vld || wd_expire) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (soft_rst) state_d = StIdle;
  end

  always_comb begin
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    wd_d         = wd_q;
    up_ack_vld_d = '0;
    up_rd_data_d = up_rd_data_q;
    up_err_d     = 1'b0;
    dn_req_vld_d = dn_req_vld_q;
    dn_addr_d    = dn_addr_q;
    dn_wr_en_d   = dn_wr_en_q;
    dn_rd_en_d   = dn_rd_en_q;
    dn_wr_data_d = dn_wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (arb_vld) begin
          grant_d      = arb_idx;
          ptr_d        = (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + IdxW'(1);
          dn_req_vld_d = 1'b1;
          wd_d         = '0;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
              dn_addr_d    = up_addr[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
              dn_wr_en_d   = up_wr_en[i];
              dn_rd_en_d   = up_rd_en[i];
              dn_wr_data_d = up_wr_data[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            end
          end
        end
      end
      StBusy: begin
        // A real ack on the expiry cycle takes precedence over the timeout.
        if (dn_ack_vld) begin
          dn_req_vld_d          = 1'b0;
          up_ack_vld_d[grant_q] = 1'b1;
          up_rd_data_d          = dn_rd_data;
        end else if (wd_expire) begin
          dn_req_vld_d          = 1'b0;
          up_ack_vld_d[grant_q] = 1'b1;
          up_rd_data_d          = TimeoutRdataExt;
          up_err_d              = 1'b1;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StGap:   dn_req_vld_d = 1'b0;
      default: dn_req_vld_d = 1'b0;
    endcase

    if (soft_rst) begin
      ptr_d        = '0;
      grant_d      = '0;
      wd_d         = '0;
      up_ack_vld_d = '0;
      up_rd_data_d = '0;
      up_err_d     = 1'b0;
      dn_req_vld_d = 1'b0;
      dn_addr_d    = '0;
      dn_wr_en_d   = 1'b0;
      dn_rd_en_d   = 1'b0;
      dn_wr_data_d = '0;
    end
  end

  always_ff @(posedge native_clk or negedge native_rst_n) begin
    if (!native_rst_n) begin
      ptr_q        <= '0;
      grant_q      <= '0;
      wd_q         <= '0;
      up_ack_vld_q <= '0;
      up_rd_data_q <= '0;
      up_err_q     <= 1'b0;
      dn_req_vld_q <= 1'b0;
      dn_addr_q    <= '0;
      dn_wr_en_q   <= 1'b0;
      dn_rd_en_q   <= 1'b0;
      dn_wr_data_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      wd_q         <= wd_d;
      up_ack_vld_q <= up_ack_vld_d;
      up_rd_data_q <= up_rd_data_d;
      up_err_q     <= up_err_d;
      dn_req_vld_q <= dn_req_vld_d;
      dn_addr_q    <= dn_addr_d;
      dn_wr_en_q   <= dn_wr_en_d;
      dn_rd_en_q   <= dn_rd_en_d;
      dn_wr_data_q <= dn_wr_data_d;
    end
  end

  assign up_ack_vld = up_ack_vld_q;
  assign up_rd_data = up_rd_data_q;
  assign up_err     = up_err_q;
  assign dn_req_vld = dn_req_vld_q;
  assign dn_addr    = dn_addr_q;
  assign dn_wr_en   = dn_wr_en_q;
  assign dn_rd_en   = dn_rd_en_q;
  assign dn_wr_data = dn_wr_data_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_reg_native_if_arbiter.sv
// Directed bench for reg_native_if_arbiter: reads, writes, round-robin order, watchdog, resets.
module tb_reg_native_if_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Dw   = 32;
  localparam int unsigned Aw   = 64;
  localparam int unsigned Tc   = 8;

  logic                 native_clk = 1'b0;
  logic                 native_rst_n;
  logic                 soft_rst;
  logic [NReq-1:0]      up_req_vld, up_wr_en, up_rd_en, up_ack_vld;
  logic [NReq*Aw-1:0]   up_addr;
  logic [NReq*Dw-1:0]   up_wr_data;
  logic [Dw-1:0]        up_rd_data, dn_wr_data, dn_rd_data;
  logic                 up_err, dn_req_vld, dn_wr_en, dn_rd_en, dn_ack_vld;
  logic [Aw-1:0]        dn_addr;
  logic [1:0]           grant_id;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  reg_native_if_arbiter #(
    .N_REQ          (NReq),
    .BUS_DATA_WIDTH (Dw),
    .BUS_ADDR_WIDTH (Aw),
    .TIMEOUT_CYCLES (Tc),
    .TIMEOUT_RDATA  (32'hDEAD_BEEF)
  ) dut (
    .native_clk   (native_clk),
    .native_rst_n (native_rst_n),
    .soft_rst     (soft_rst),
    .up_req_vld   (up_req_vld),
    .up_addr      (up_addr),
    .up_wr_en     (up_wr_en),
    .up_rd_en     (up_rd_en),
    .up_wr_data   (up_wr_data),
    .up_ack_vld   (up_ack_vld),
    .up_rd_data   (up_rd_data),
    .up_err       (up_err),
    .dn_req_vld   (dn_req_vld),
    .dn_addr      (dn_addr),
    .dn_wr_en     (dn_wr_en),
    .dn_rd_en     (dn_rd_en),
    .dn_wr_data   (dn_wr_data),
    .dn_ack_vld   (dn_ack_vld),
    .dn_rd_data   (dn_rd_data),
    .grant_id     (grant_id)
  );

  always #5 native_clk = ~native_clk;

  task automatic step();
    @(posedge native_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [63:0] a, input logic wr, input logic rd,
                          input logic [31:0] d);
    up_addr[i*Aw +: Aw]    = a;
    up_wr_en[i]            = wr;
    up_rd_en[i]            = rd;
    up_wr_data[i*Dw +: Dw] = d;
  endtask

  initial begin
    native_rst_n = 1'b0;
    soft_rst     = 1'b0;
    up_req_vld   = '0;
    up_addr      = '0;
    up_wr_en     = '0;
    up_rd_en     = '0;
    up_wr_data   = '0;
    dn_ack_vld   = 1'b0;
    dn_rd_data   = '0;
    #2;
    chk("rst_dn_req", 64'(dn_req_vld), 64'd0);
    chk("rst_ack", 64'(up_ack_vld), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_err", 64'(up_err), 64'd0);
    chk("rst_rdata", 64'(up_rd_data), 64'd0);
    step();
    step();
    native_rst_n = 1'b1;
    step();

    // Single read from requester 2, ack three cycles after the request goes out.
    set_slot(2, 64'h0000_0000_0000_1020, 1'b0, 1'b1, 32'h0);
    up_req_vld = 4'b0100;
    step();
    chk("t1_dn_req", 64'(dn_req_vld), 64'd1);
    chk("t1_grant", 64'(grant_id), 64'd2);
    chk("t1_addr", dn_addr, 64'h0000_0000_0000_1020);
    chk("t1_rd_en", 64'(dn_rd_en), 64'd1);
    chk("t1_wr_en", 64'(dn_wr_en), 64'd0);
    step();
    step();
    chk("t1_hold", 64'(dn_req_vld), 64'd1);
    chk("t1_no_ack", 64'(up_ack_vld), 64'd0);
    dn_ack_vld = 1'b1;
    dn_rd_data = 32'h1234_5678;
    step();
    chk("t1_ack", 64'(up_ack_vld), 64'b0100);
    chk("t1_rdata", 64'(up_rd_data), 64'h1234_5678);
    chk("t1_err", 64'(up_err), 64'd0);
    chk("t1_dn_drop", 64'(dn_req_vld), 64'd0);
    dn_ack_vld = 1'b0;
    up_req_vld = '0;
    step();
    chk("t1_ack_pulse", 64'(up_ack_vld), 64'd0);

    // Soft reset, then requesters 0 (write) and 2 (read) together.
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    chk("srst_grant", 64'(grant_id), 64'd0);
    set_slot(0, 64'hAAAA_0000_0000_0000, 1'b1, 1'b0, 32'hCAFE_0000);
    set_slot(2, 64'h2222_0000_0000_0002, 1'b0, 1'b1, 32'h0);
    up_req_vld = 4'b0101;
    step();
    chk("t2_grant0", 64'(grant_id), 64'd0);
    chk("t2_addr0", dn_addr, 64'hAAAA_0000_0000_0000);
    chk("t2_wr_en0", 64'(dn_wr_en), 64'd1);
    chk("t2_wdata0", 64'(dn_wr_data), 64'hCAFE_0000);
    dn_ack_vld = 1'b1;
    step();
    chk("t2_ack0", 64'(up_ack_vld), 64'b0001);
    up_req_vld = 4'b0100;
    dn_ack_vld = 1'b0;
    step();
    chk("t2_gap_low", 64'(dn_req_vld), 64'd0);
    step();
    chk("t2_grant2", 64'(grant_id), 64'd2);
    chk("t2_addr2", dn_addr, 64'h2222_0000_0000_0002);
    dn_ack_vld = 1'b1;
    dn_rd_data = 32'h0BAD_F00D;
    step();
    chk("t2_ack2", 64'(up_ack_vld), 64'b0100);
    chk("t2_rdata2", 64'(up_rd_data), 64'h0BAD_F00D);
    dn_ack_vld = 1'b0;
    up_req_vld = '0;
    step();

    // All four request continuously: expect 0,1,2,3,0.
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    for (int i = 0; i < 4; i++) set_slot(i, 64'h4000 + 64'(i), 1'b0, 1'b1, 32'h0);
    up_req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t3_grant%0d", k), 64'(grant_id), 64'(k % 4));
      chk($sformatf("t3_addr%0d", k), dn_addr, 64'h4000 + 64'(k % 4));
      dn_ack_vld = 1'b1;
      dn_rd_data = 32'h100 + 32'(k);
      step();
      chk($sformatf("t3_ack%0d", k), 64'(up_ack_vld), 64'(4'b0001 << (k % 4)));
      dn_ack_vld           = 1'b0;
      up_req_vld[k % 4]    = 1'b0;
      step();
      up_req_vld[k % 4]    = 1'b1;
    end
    up_req_vld = '0;

    // Watchdog: pointer is 1, requester 1 never acked.
    set_slot(1, 64'h0000_0000_0000_0B0B, 1'b0, 1'b1, 32'h0);
    up_req_vld = 4'b0010;
    step();
    chk("t4_grant", 64'(grant_id), 64'd1);
    chk("t4_high1", 64'(dn_req_vld), 64'd1);
    for (int c = 2; c <= Tc; c++) begin
      step();
      chk($sformatf("t4_high%0d", c), 64'(dn_req_vld), 64'd1);
    end
    chk("t4_no_ack", 64'(up_ack_vld), 64'd0);
    step();
    chk("t4_to_ack", 64'(up_ack_vld), 64'b0010);
    chk("t4_to_err", 64'(up_err), 64'd1);
    chk("t4_to_rdata", 64'(up_rd_data), 64'hDEAD_BEEF);
    chk("t4_to_drop", 64'(dn_req_vld), 64'd0);
    up_req_vld = '0;
    dn_ack_vld = 1'b1;
    dn_rd_data = 32'h5555_5555;
    step();
    chk("t4_late_ack", 64'(up_ack_vld), 64'd0);
    chk("t4_late_err", 64'(up_err), 64'd0);
    step();
    chk("t4_late_idle", 64'(up_ack_vld), 64'd0);
    chk("t4_late_req", 64'(dn_req_vld), 64'd0);
    dn_ack_vld = 1'b0;

    // Ack lands exactly on the expiry cycle: normal completion.
    set_slot(2, 64'h0000_0000_0000_0C0C, 1'b0, 1'b1, 32'h0);
    up_req_vld = 4'b0100;
    step();
    chk("t5_grant", 64'(grant_id), 64'd2);
    for (int c = 2; c <= Tc; c++) step();
    chk("t5_high8", 64'(dn_req_vld), 64'd1);
    dn_ack_vld = 1'b1;
    dn_rd_data = 32'hA5A5_0F0F;
    step();
    chk("t5_ack", 64'(up_ack_vld), 64'b0100);
    chk("t5_err", 64'(up_err), 64'd0);
    chk("t5_rdata", 64'(up_rd_data), 64'hA5A5_0F0F);
    dn_ack_vld = 1'b0;
    up_req_vld = '0;
    step();
    step();

    // Async reset mid-BUSY, then pointer restarts at 0.
    set_slot(3, 64'h0000_0000_0000_0D0D, 1'b0, 1'b1, 32'h0);
    up_req_vld = 4'b1000;
    step();
    chk("t6_grant3", 64'(grant_id), 64'd3);
    step();
    native_rst_n = 1'b0;
    #1;
    chk("t6_rst_drop", 64'(dn_req_vld), 64'd0);
    chk("t6_rst_grant", 64'(grant_id), 64'd0);
    step();
    chk("t6_rst_no_ack", 64'(up_ack_vld), 64'd0);
    up_req_vld   = '0;
    native_rst_n = 1'b1;
    step();
    chk("t6_post_no_ack", 64'(up_ack_vld), 64'd0);
    set_slot(1, 64'h0000_0000_0000_0E01, 1'b1, 1'b0, 32'h7777_1111);
    up_req_vld = 4'b1010;
    step();
    chk("t6_ptr0_grant", 64'(grant_id), 64'd1);
    chk("t6_wdata", 64'(dn_wr_data), 64'h7777_1111);
    dn_ack_vld = 1'b1;
    step();
    chk("t6_ack1", 64'(up_ack_vld), 64'b0010);
    dn_ack_vld = 1'b0;
    up_req_vld = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
